// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding, nibble width and the flag
// bundle that the result mux also consumes.
package alu_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/carry_lookahead_adder_4bit.sv
// 4-bit carry-lookahead adder slice: generate/propagate per bit, all carries
// computed in parallel from the carry-in.
module carry_lookahead_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/alu_nibble_add_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract that pushes one nibble per cycle, LSB first,
// through a single shared 4-bit CLA slice; carry between nibbles lives in carry_q.
module alu_nibble_add_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
            $error("alu_nibble_add_sequencer: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    // Signed overflow: operands agree in sign but the result sign differs.
    function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    alu_flags_t       flags_q;

    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;
    logic [WIDTH-1:0]    result_next;

    assign slice_a = a_q[NIBBLE_W*idx +: NIBBLE_W];
    assign slice_b = b_q[NIBBLE_W*idx +: NIBBLE_W];

    carry_lookahead_adder_4bit u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        result_next = result;
        result_next[NIBBLE_W*idx +: NIBBLE_W] = slice_sum;
    end

    assign cout     = flags_q.cout;
    assign overflow = flags_q.overflow;
    assign zero     = flags_q.zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            result    <= '0;
            flags_q   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        // Subtract is A + ~B + 1: the +1 enters as the first carry-in.
                        a_q      <= a;
                        b_q      <= op_sub ? ~b : b;
                        carry_q  <= op_sub;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result  <= result_next;
                    carry_q <= slice_cout;
                    if (idx == LAST_IDX) begin
                        flags_q.cout     <= slice_cout;
                        flags_q.overflow <= signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1],
                                                       slice_sum[NIBBLE_W-1]);
                        flags_q.zero     <= (result_next == '0);
                        out_valid        <= 1'b1;
                        idx              <= '0;
                        state            <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
